// File: rtl/radiant_event_hdr_gen.sv
// Event header generator: PPS/event/clock counters, a DEPTH-entry header buffer,
// and a word-serial valid/ready readout with drop accounting, wrap flags and type masking.
module radiant_event_hdr_gen #(
  parameter int unsigned CNT_W  = 48,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TYPE_W = 4,
  parameter logic [31:0] ID     = "RDE1"
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       pps_i,
  input  logic                       event_i,
  input  logic [TYPE_W-1:0]          event_type_i,
  input  logic [31:0]                event_info_i,
  input  logic [(2**TYPE_W)-1:0]     type_mask_i,
  input  logic                       sync_arm_i,
  input  logic                       flush_i,
  output logic [31:0]                hdr_data_o,
  output logic                       hdr_valid_o,
  output logic                       hdr_last_o,
  input  logic                       hdr_ready_i,
  output logic [$clog2(DEPTH):0]     pending_o,
  output logic                       sync_armed_o,
  output logic [15:0]                dropped_o
);

  localparam int unsigned NUM_WORDS = 8;
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned ENTRY_W   = 32 * (NUM_WORDS - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [CNT_W-1:0]   pps_cnt_q, pps_cnt_d;
  logic [CNT_W-1:0]   evt_cnt_q, evt_cnt_d;
  logic [31:0]        last_q, last_d;
  logic [31:0]        last2_q, last2_d;
  logic               clk_wrap_q, clk_wrap_d;
  logic               pps_wrap_q, pps_wrap_d;
  logic               evt_wrap_q, evt_wrap_d;
  logic [15:0]        dropped_q, dropped_d;
  logic               armed_q, armed_d;

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic               type_en;
  logic               handshake;
  logic               pop;
  logic               full;
  logic               accept;
  logic               drop;
  logic               sync_fire;
  logic [7:0]         type_ext;
  logic [31:0]        status_w;
  logic [ENTRY_W-1:0] entry_w;
  logic [ENTRY_W-1:0] rd_entry;
  logic [31:0]        words [NUM_WORDS];

  assign type_en   = type_mask_i[event_type_i];
  assign handshake = (state_q == STREAM) && hdr_ready_i;
  assign pop       = handshake && (idx_q == 3'd7) && !flush_i;
  assign full      = (count_q == (AW+1)'(DEPTH));
  // A pop on the same edge frees the slot, so a full buffer can still accept.
  assign accept    = event_i && type_en && !flush_i && (!full || pop);
  assign drop      = event_i && type_en && !accept;
  assign sync_fire = pps_i && armed_q && !sync_arm_i;

  always_comb begin
    type_ext = '0;
    type_ext[TYPE_W-1:0] = event_type_i;
  end

  assign status_w = {5'b0, clk_wrap_q, pps_wrap_q, evt_wrap_q, type_ext, dropped_q};
  assign entry_w  = {last2_q, last_q, status_w, event_info_i,
                     clk_cnt_q[31:0], evt_cnt_q[31:0], pps_cnt_q[31:0]};

  // Counters, timestamps, wrap flags and drop count
  always_comb begin
    clk_cnt_d  = clk_cnt_q + CNT_W'(1);
    pps_cnt_d  = pps_cnt_q;
    evt_cnt_d  = evt_cnt_q;
    last_d     = last_q;
    last2_d    = last2_q;
    clk_wrap_d = clk_wrap_q;
    pps_wrap_d = pps_wrap_q;
    evt_wrap_d = evt_wrap_q;
    dropped_d  = dropped_q;
    armed_d    = armed_q;

    if (pps_i) begin
      pps_cnt_d = pps_cnt_q + CNT_W'(1);
      last_d    = clk_cnt_q[31:0];
      last2_d   = last_q;
    end
    if (accept) begin
      evt_cnt_d  = evt_cnt_q + CNT_W'(1);
      clk_wrap_d = 1'b0;
      pps_wrap_d = 1'b0;
      evt_wrap_d = 1'b0;
    end
    if (drop && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end

    // A wrap coinciding with an acceptance must survive into the next header.
    if (&clk_cnt_q[31:0])           clk_wrap_d = 1'b1;
    if (pps_i && (&pps_cnt_q[31:0])) pps_wrap_d = 1'b1;
    if (accept && (&evt_cnt_q[31:0])) evt_wrap_d = 1'b1;

    if (sync_arm_i) begin
      armed_d = 1'b1;
    end else if (sync_fire) begin
      armed_d = 1'b0;
    end

    if (sync_fire) begin
      clk_cnt_d  = '0;
      pps_cnt_d  = '0;
      evt_cnt_d  = '0;
      last_d     = '0;
      last2_d    = '0;
      clk_wrap_d = 1'b0;
      pps_wrap_d = 1'b0;
      evt_wrap_d = 1'b0;
      dropped_d  = '0;
    end
  end

  // Buffer pointers and readout FSM
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idx_d    = idx_q;
    state_d  = state_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      idx_d    = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(accept) - (AW+1)'(pop);
      if (handshake) idx_d = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
    end

    // Entering STREAM on the write edge gives word 0 one cycle after acceptance.
    case (state_q)
      IDLE:    if (count_d != '0) state_d = STREAM;
      STREAM:  if (count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_cnt_q  <= '0;
      pps_cnt_q  <= '0;
      evt_cnt_q  <= '0;
      last_q     <= '0;
      last2_q    <= '0;
      clk_wrap_q <= 1'b0;
      pps_wrap_q <= 1'b0;
      evt_wrap_q <= 1'b0;
      dropped_q  <= '0;
      armed_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      state_q    <= IDLE;
    end else begin
      clk_cnt_q  <= clk_cnt_d;
      pps_cnt_q  <= pps_cnt_d;
      evt_cnt_q  <= evt_cnt_d;
      last_q     <= last_d;
      last2_q    <= last2_d;
      clk_wrap_q <= clk_wrap_d;
      pps_wrap_q <= pps_wrap_d;
      evt_wrap_q <= evt_wrap_d;
      dropped_q  <= dropped_d;
      armed_q    <= armed_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem_q[wr_ptr_q] <= entry_w;
  end

  assign rd_entry = mem_q[rd_ptr_q];

  always_comb begin
    words[0] = ID;
    for (int unsigned w = 1; w < NUM_WORDS; w++) begin
      words[w] = rd_entry[32*(w-1) +: 32];
    end
  end

  assign hdr_valid_o  = (state_q == STREAM);
  assign hdr_last_o   = hdr_valid_o && (idx_q == 3'd7);
  assign hdr_data_o   = hdr_valid_o ? words[idx_q] : '0;
  assign pending_o    = count_q;
  assign sync_armed_o = armed_q;
  assign dropped_o    = dropped_q;

endmodule

// File: tb/tb_radiant_event_hdr_gen.sv
// Scoreboard bench for radiant_event_hdr_gen: stimulus pushes expected header words,
// a negedge monitor pops and compares them on every accepted output word.
module tb_radiant_event_hdr_gen;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TYPE_W = 4;
  localparam logic [31:0] ID_W   = 32'h52444531;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pps = 1'b0;
  logic        ev_i = 1'b0;
  logic [3:0]  ev_type = '0;
  logic [31:0] ev_info = '0;
  logic [15:0] mask = '1;
  logic        arm = 1'b0;
  logic        flush = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] hdr_data;
  logic        hdr_valid;
  logic        hdr_last;
  logic [4:0]  pending;
  logic        armed;
  logic [15:0] dropped;

  radiant_event_hdr_gen #(
    .CNT_W (48),
    .DEPTH (DEPTH),
    .TYPE_W(TYPE_W)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .pps_i       (pps),
    .event_i     (ev_i),
    .event_type_i(ev_type),
    .event_info_i(ev_info),
    .type_mask_i (mask),
    .sync_arm_i  (arm),
    .flush_i     (flush),
    .hdr_data_o  (hdr_data),
    .hdr_valid_o (hdr_valid),
    .hdr_last_o  (hdr_last),
    .hdr_ready_i (ready),
    .pending_o   (pending),
    .sync_armed_o(armed),
    .dropped_o   (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic        last;
    int unsigned idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Expected clock-counter value: edges since reset or since the last sync.
  int unsigned tcnt;
  logic        tb_sync = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tcnt <= 0;
    else if (tb_sync) tcnt <= 0;
    else              tcnt <= tcnt + 1;
  end

  always @(negedge clk) begin
    if (rst_n && hdr_valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL hdr_word unexpected: got %h, none expected", hdr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ((((hdr_data ^ mon_e.data) & mon_e.mask) != 0) || (hdr_last !== mon_e.last)) begin
          errors++;
          $display("FAIL hdr_word%0d: got %h last=%b, expected %h last=%b (mask %h)",
                   mon_e.idx, hdr_data, hdr_last, mon_e.data, mon_e.last, mon_e.mask);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic [31:0] m, input int unsigned i);
    exp_t e;
    e.data = d;
    e.mask = m;
    e.last = (i == 7);
    e.idx  = i;
    exp_q.push_back(e);
  endtask

  task automatic push_hdr(input logic [31:0] p, input logic [31:0] e, input logic [31:0] c,
                          input logic [31:0] info, input logic [31:0] st,
                          input logic [31:0] l, input logic [31:0] l2, input logic c_known);
    push_word(ID_W, '1, 0);
    push_word(p, '1, 1);
    push_word(e, '1, 2);
    push_word(c, c_known ? 32'hFFFF_FFFF : 32'h0, 3);
    push_word(info, '1, 4);
    push_word(st, '1, 5);
    push_word(l, '1, 6);
    push_word(l2, '1, 7);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int unsigned c);
    int unsigned guard = 0;
    while (tcnt != c && guard < 1000) begin
      tick();
      guard++;
    end
    if (tcnt != c) chk("wait_cnt_timeout", tcnt, c);
  endtask

  task automatic do_event(input logic [3:0] t, input logic [31:0] info, output logic [31:0] c);
    ev_i    = 1'b1;
    ev_type = t;
    ev_info = info;
    c       = tcnt;
    tick();
    ev_i    = 1'b0;
  endtask

  task automatic do_pps(output logic [31:0] c);
    pps = 1'b1;
    c   = tcnt;
    tick();
    pps = 1'b0;
  endtask

  task automatic drain();
    int unsigned guard = 0;
    while ((exp_q.size() != 0 || hdr_valid) && guard < 2000) begin
      tick();
      guard++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c, c2, p1, p2, px;
    ready = 1'b1;
    tick(); tick();
    chk("rst_valid", hdr_valid, 0);
    chk("rst_last", hdr_last, 0);
    chk("rst_data", hdr_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_armed", armed, 0);
    chk("rst_dropped", dropped, 0);
    rst_n = 1'b1;

    // Basic headers with PPS history
    wait_cnt(3);  do_pps(p1);
    wait_cnt(7);  do_pps(p2);
    wait_cnt(10);
    push_hdr(2, 0, 10, 32'hA000_0001, 32'h0001_0000, 7, 3, 1'b1);
    do_event(4'd1, 32'hA000_0001, c);
    chk("valid_after_accept", hdr_valid, 1);
    chk("pending_after_accept", pending, 1);
    wait_cnt(20);
    push_hdr(2, 1, 20, 32'hA000_0002, 32'h0005_0000, 7, 3, 1'b1);
    do_event(4'd5, 32'hA000_0002, c);
    wait_cnt(30);
    push_hdr(2, 2, 30, 32'hA000_0003, 32'h000F_0000, 7, 3, 1'b1);
    do_event(4'd15, 32'hA000_0003, c);
    drain();

    // Fill with readout stalled, overflow by two
    ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      do_event(4'(i), 32'hB000_0000 + 32'(i), c);
      if (i < 16) push_hdr(2, 32'(3 + i), c, 32'hB000_0000 + 32'(i), 32'(i) << 16, 7, 3, 1'b1);
    end
    chk("full_pending", pending, 16);
    chk("full_dropped", dropped, 2);
    ready = 1'b1;
    repeat (120) tick();
    chk("b2b_pending_120", pending, 1);
    chk("b2b_valid_120", hdr_valid, 1);
    repeat (8) tick();
    chk("b2b_pending_128", pending, 0);
    chk("b2b_valid_128", hdr_valid, 0);
    push_hdr(2, 19, tcnt, 32'hB100_0000, 32'h0003_0002, 7, 3, 1'b1);
    do_event(4'd3, 32'hB100_0000, c);
    drain();

    // Arm and PPS together: arm only, PPS still counted
    arm = 1'b1; pps = 1'b1; px = tcnt;
    tick();
    arm = 1'b0; pps = 1'b0;
    chk("arm_with_pps", armed, 1);
    repeat (3) tick();
    chk("still_armed", armed, 1);

    // Sync coinciding with an event: header holds pre-sync values
    push_hdr(3, 20, tcnt, 32'hC000_0000, 32'h0009_0002, px, 7, 1'b1);
    pps = 1'b1; ev_i = 1'b1; ev_type = 4'd9; ev_info = 32'hC000_0000; tb_sync = 1'b1;
    tick();
    pps = 1'b0; ev_i = 1'b0; tb_sync = 1'b0;
    chk("sync_armed_clr", armed, 0);
    chk("sync_dropped_clr", dropped, 0);
    chk("sync_pps_cnt", dut.pps_cnt_q[31:0], 0);
    chk("sync_evt_cnt", dut.evt_cnt_q[31:0], 0);
    chk("sync_clk_cnt", dut.clk_cnt_q[31:0], 0);
    tick();
    chk("sync_clk_cnt_next", dut.clk_cnt_q[31:0], 1);
    drain();

    // Type mask selects type 2 only
    mask = 16'h0004;
    do_event(4'd1, 32'hD000_0001, c);
    push_hdr(0, 0, tcnt, 32'hD000_0002, 32'h0002_0000, 0, 0, 1'b1);
    do_event(4'd2, 32'hD000_0002, c2);
    do_event(4'd3, 32'hD000_0003, c);
    drain();
    chk("mask_dropped", dropped, 0);
    chk("mask_pending", pending, 0);
    mask = '1;

    // Mid-header flush with an event in the flush cycle
    ready = 1'b0;
    do_event(4'd4, 32'hE000_0001, c);
    do_event(4'd5, 32'hE000_0002, c);
    chk("flush_pre_pending", pending, 2);
    push_word(ID_W, '1, 0);
    push_word(32'd0, '1, 1);
    push_word(32'd1, '1, 2);
    ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0; flush = 1'b1; ev_i = 1'b1; ev_type = 4'd6;
    tick();
    flush = 1'b0; ev_i = 1'b0;
    chk("flush_valid", hdr_valid, 0);
    chk("flush_pending", pending, 0);
    chk("flush_dropped", dropped, 1);
    chk("flush_words_left", exp_q.size(), 0);
    ready = 1'b1;
    push_hdr(0, 3, tcnt, 32'hE000_0003, 32'h0007_0001, 0, 0, 1'b1);
    do_event(4'd7, 32'hE000_0003, c);
    drain();

    // Clock-counter wrap flag
    force dut.clk_cnt_q = 48'h0000_FFFF_FFF0;
    #2;
    release dut.clk_cnt_q;
    repeat (20) tick();
    push_hdr(0, 4, 0, 32'hF000_0001, 32'h0401_0001, 0, 0, 1'b0);
    do_event(4'd1, 32'hF000_0001, c);
    push_hdr(0, 5, 0, 32'hF000_0002, 32'h0002_0001, 0, 0, 1'b0);
    do_event(4'd2, 32'hF000_0002, c);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
